// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB write-back arbiter: bus widths, source ids
// and the round-robin successor helper.
package cdb_arbiter_pkg;

  localparam int TAG_W      = 4;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int NUM_SRC    = 3;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_LSB = 2'd1;
  localparam logic [1:0] CDB_SRC_BR  = 2'd2;

  // Round-robin successor over the three producers (ALU -> LSB -> BR -> ALU).
  function automatic logic [1:0] next_src(input logic [1:0] src);
    return (src == CDB_SRC_BR) ? CDB_SRC_ALU : src + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small synchronous FIFO used as the per-producer result buffer in front of
// the CDB arbiter; push/pop act only while en is high, flush empties it.
module cdb_src_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || (en && flush)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (en && !flush && push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single ROB write-back (CDB) port between the ALU, LSB and branch
// unit: per-producer FIFOs drained round-robin onto a registered bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W      = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W     = cdb_arbiter_pkg::DATA_W,
  parameter int ADDR_W     = cdb_arbiter_pkg::ADDR_W,
  parameter int FIFO_DEPTH = cdb_arbiter_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsb_valid,
  output logic              lsb_ready,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  input  logic              br_jump,
  input  logic [ADDR_W-1:0] br_pc,
  output logic              cdb_valid,
  output logic [1:0]        cdb_src,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_jump,
  output logic [ADDR_W-1:0] cdb_pc
);

  localparam int CNT_W   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam int SIMPLE_W = TAG_W + DATA_W;
  localparam int BR_W     = TAG_W + DATA_W + 1 + ADDR_W;

  logic [CNT_W-1:0]    alu_count, lsb_count, br_count;
  logic                alu_empty, lsb_empty, br_empty;
  logic [SIMPLE_W-1:0] alu_head, lsb_head;
  logic [BR_W-1:0]     br_head;
  logic                accept;
  logic                alu_push, lsb_push, br_push;
  logic                alu_pop, lsb_pop, br_pop;
  logic [1:0]          rr_ptr;
  logic [2:0]          pending;
  logic                grant;
  logic [1:0]          grant_src;
  logic [1:0]          cand;
  logic [TAG_W-1:0]    head_tag;
  logic [DATA_W-1:0]   head_data;
  logic                head_jump;
  logic [ADDR_W-1:0]   head_pc;

  // Handshake: a producer holds valid and payload stable until it sees ready;
  // the beat transfers on the edge where valid && ready && rdy && !clear.
  // ready depends only on the registered count, never on valid or on a pop.
  assign alu_ready = (alu_count < CNT_W'(FIFO_DEPTH));
  assign lsb_ready = (lsb_count < CNT_W'(FIFO_DEPTH));
  assign br_ready  = (br_count  < CNT_W'(FIFO_DEPTH));

  assign accept   = rdy && !clear;
  assign alu_push = alu_valid && alu_ready && accept;
  assign lsb_push = lsb_valid && lsb_ready && accept;
  assign br_push  = br_valid  && br_ready  && accept;

  assign alu_pop = accept && grant && (grant_src == CDB_SRC_ALU);
  assign lsb_pop = accept && grant && (grant_src == CDB_SRC_LSB);
  assign br_pop  = accept && grant && (grant_src == CDB_SRC_BR);

  cdb_src_fifo #(.WIDTH(SIMPLE_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .en(rdy), .flush(clear),
    .push(alu_push), .wdata({alu_tag, alu_data}),
    .pop(alu_pop), .rdata(alu_head), .count(alu_count), .empty(alu_empty)
  );

  cdb_src_fifo #(.WIDTH(SIMPLE_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst(rst), .en(rdy), .flush(clear),
    .push(lsb_push), .wdata({lsb_tag, lsb_data}),
    .pop(lsb_pop), .rdata(lsb_head), .count(lsb_count), .empty(lsb_empty)
  );

  cdb_src_fifo #(.WIDTH(BR_W), .DEPTH(FIFO_DEPTH)) u_br_fifo (
    .clk(clk), .rst(rst), .en(rdy), .flush(clear),
    .push(br_push), .wdata({br_tag, br_data, br_jump, br_pc}),
    .pop(br_pop), .rdata(br_head), .count(br_count), .empty(br_empty)
  );

  assign pending = {!br_empty, !lsb_empty, !alu_empty};

  // First non-empty source at or after the round-robin pointer wins.
  always_comb begin
    grant     = 1'b0;
    grant_src = rr_ptr;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant && pending[cand]) begin
        grant     = 1'b1;
        grant_src = cand;
      end
      cand = next_src(cand);
    end
  end

  always_comb begin
    head_tag  = alu_head[SIMPLE_W-1 -: TAG_W];
    head_data = alu_head[DATA_W-1:0];
    head_jump = 1'b0;
    head_pc   = '0;
    case (grant_src)
      CDB_SRC_LSB: begin
        head_tag  = lsb_head[SIMPLE_W-1 -: TAG_W];
        head_data = lsb_head[DATA_W-1:0];
      end
      CDB_SRC_BR: begin
        head_tag  = br_head[BR_W-1 -: TAG_W];
        head_data = br_head[ADDR_W+1 +: DATA_W];
        head_jump = br_head[ADDR_W];
        head_pc   = br_head[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= CDB_SRC_ALU;
      cdb_valid <= 1'b0;
      cdb_src   <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_jump  <= 1'b0;
      cdb_pc    <= '0;
    end else if (rdy) begin
      if (!clear && grant) begin
        rr_ptr    <= next_src(grant_src);
        cdb_valid <= 1'b1;
        cdb_src   <= grant_src;
        cdb_tag   <= head_tag;
        cdb_data  <= head_data;
        cdb_jump  <= head_jump;
        cdb_pc    <= head_pc;
      end else begin
        if (clear) rr_ptr <= CDB_SRC_ALU;
        cdb_valid <= 1'b0;
        cdb_src   <= '0;
        cdb_tag   <= '0;
        cdb_data  <= '0;
        cdb_jump  <= 1'b0;
        cdb_pc    <= '0;
      end
    end
  end

endmodule
